id_ex_stage: RTL

Decode-to-execute pipeline register and operand-select stage of the 5-stage MIPS core; sits directly upstream of the ALU and drives its `SrcA`, `SrcB` and `ALUControl` inputs. It captures decoded control and register-file operands every cycle. It resolves RAW hazards by forwarding from the MEM and WB stages, and applies the immediate and destination-register muxes. It honours stall and flush (bubble) requests from the hazard unit.

---
 rtl/id_ex_stage_if.sv | 65 ++++++
 rtl/id_ex_stage.sv | 116 +++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// Decode/execute bundle: D-side inputs, hazard controls,
// M/W forwarding sources and E-side outputs.
interface id_ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
);
  logic             StallE;
  logic             FlushE;
  logic             RegWriteD;
  logic             MemtoRegD;
  logic             MemWriteD;
  logic             ALUSrcD;
  logic             RegDstD;
  logic [2:0]       ALUControlD;
  logic [WIDTH-1:0] RD1D;
  logic [WIDTH-1:0] RD2D;
  logic [REGW-1:0]  RsD;
  logic [REGW-1:0]  RtD;
  logic [REGW-1:0]  RdD;
  logic [WIDTH-1:0] SignImmD;
  logic             RegWriteM;
  logic [REGW-1:0]  WriteRegM;
  logic [WIDTH-1:0] ALUOutM;
  logic             RegWriteW;
  logic [REGW-1:0]  WriteRegW;
  logic [WIDTH-1:0] ResultW;
  logic             RegWriteE;
  logic             MemtoRegE;
  logic             MemWriteE;
  logic [2:0]       ALUControlE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic [WIDTH-1:0] WriteDataE;
  logic [REGW-1:0]  WriteRegE;
  logic [REGW-1:0]  RsE;
  logic [REGW-1:0]  RtE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;

  modport master (
    output StallE, FlushE,
    output RegWriteD, MemtoRegD, MemWriteD,
    output ALUSrcD, RegDstD, ALUControlD,
    output RD1D, RD2D, RsD, RtD, RdD, SignImmD,
    output RegWriteM, WriteRegM, ALUOutM,
    output RegWriteW, WriteRegW, ResultW,
    input  RegWriteE, MemtoRegE, MemWriteE,
    input  ALUControlE, SrcAE, SrcBE,
    input  WriteDataE, WriteRegE, RsE, RtE,
    input  ForwardAE, ForwardBE
  );

  modport slave (
    input  StallE, FlushE,
    input  RegWriteD, MemtoRegD, MemWriteD,
    input  ALUSrcD, RegDstD, ALUControlD,
    input  RD1D, RD2D, RsD, RtD, RdD, SignImmD,
    input  RegWriteM, WriteRegM, ALUOutM,
    input  RegWriteW, WriteRegW, ResultW,
    output RegWriteE, MemtoRegE, MemWriteE,
    output ALUControlE, SrcAE, SrcBE,
    output WriteDataE, WriteRegE, RsE, RtE,
    output ForwardAE, ForwardBE
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding and
// immediate / destination-register operand selection.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic             reg_write;
    logic             memto_reg;
    logic             mem_write;
    logic             alu_src;
    logic             reg_dst;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] sign_imm;
    logic [REGW-1:0]  rs;
    logic [REGW-1:0]  rt;
    logic [REGW-1:0]  rd;
  } stage_t;

  stage_t d;
  stage_t q;

  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  always_comb begin
    d             = '0;
    d.reg_write   = bus.RegWriteD;
    d.memto_reg   = bus.MemtoRegD;
    d.mem_write   = bus.MemWriteD;
    d.alu_src     = bus.ALUSrcD;
    d.reg_dst     = bus.RegDstD;
    d.alu_control = bus.ALUControlD;
    d.rd1         = bus.RD1D;
    d.rd2         = bus.RD2D;
    d.sign_imm    = bus.SignImmD;
    d.rs          = bus.RsD;
    d.rt          = bus.RtD;
    d.rd          = bus.RdD;
  end

  // bubble equals the reset value: a NOP
  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (bus.FlushE)
      q <= '0;
    else if (!bus.StallE)
      q <= d;
  end

  logic hit_ma, hit_wa, hit_mb, hit_wb;

  assign hit_ma = bus.RegWriteM
               && (bus.WriteRegM == q.rs)
               && (q.rs != '0);
  assign hit_wa = bus.RegWriteW
               && (bus.WriteRegW == q.rs)
               && (q.rs != '0);
  assign hit_mb = bus.RegWriteM
               && (bus.WriteRegM == q.rt)
               && (q.rt != '0);
  assign hit_wb = bus.RegWriteW
               && (bus.WriteRegW == q.rt)
               && (q.rt != '0);

  // MEM result is newer than WB, so it wins
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hit_ma)      fwd_a = 2'b10;
    else if (hit_wa) fwd_a = 2'b01;
    if (hit_mb)      fwd_b = 2'b10;
    else if (hit_wb) fwd_b = 2'b01;
  end

  always_comb begin
    op_a = q.rd1;
    op_b = q.rd2;
    unique case (fwd_a)
      2'b10:   op_a = bus.ALUOutM;
      2'b01:   op_a = bus.ResultW;
      default: op_a = q.rd1;
    endcase
    unique case (fwd_b)
      2'b10:   op_b = bus.ALUOutM;
      2'b01:   op_b = bus.ResultW;
      default: op_b = q.rd2;
    endcase
  end

  assign bus.RegWriteE   = q.reg_write;
  assign bus.MemtoRegE   = q.memto_reg;
  assign bus.MemWriteE   = q.mem_write;
  assign bus.ALUControlE = q.alu_control;
  assign bus.SrcAE       = op_a;
  assign bus.WriteDataE  = op_b;
  assign bus.SrcBE       = q.alu_src
                         ? q.sign_imm : op_b;
  assign bus.WriteRegE   = q.reg_dst
                         ? q.rd : q.rt;
  assign bus.RsE         = q.rs;
  assign bus.RtE         = q.rt;
  assign bus.ForwardAE   = fwd_a;
  assign bus.ForwardBE   = fwd_b;

endmodule
